// File: rtl/redun_mul_seq.sv
// Word-serial multi-mode multiplier for redundant-form operands: A*B, A*A, A*B+C, low-half A*B.
// Define REDUN_MUL_ADD_TERM_EN to enable the C addend of mode 2; otherwise mode 2 computes A*B.
module redun_mul_seq #(
    parameter int NUM_WRDS = 3,
    parameter int WRD_BITS = 16
) (
    input  logic                                   i_clk,
    input  logic                                   i_rst,
    input  logic                                   i_val,
    output logic                                   o_rdy,
    input  logic [1:0]                             i_ctl,
    input  logic [NUM_WRDS*(WRD_BITS+1)-1:0]       i_dat_a,
    input  logic [NUM_WRDS*(WRD_BITS+1)-1:0]       i_dat_b,
    input  logic [NUM_WRDS*(WRD_BITS+1)-1:0]       i_add_term,
    output logic                                   o_val,
    input  logic                                   i_rdy,
    output logic [1:0]                             o_ctl,
    output logic [2*NUM_WRDS*(WRD_BITS+1)-1:0]     o_dat
);

    localparam int WB       = WRD_BITS + 1;
    localparam int ACC_BITS = 2*WB + $clog2(NUM_WRDS) + 2;
    localparam int CNT_BITS = $clog2(2*NUM_WRDS);
    localparam int RES_BITS = 2*NUM_WRDS*WB;

    localparam logic [CNT_BITS-1:0] LAST_HALF = CNT_BITS'(NUM_WRDS-1);
    localparam logic [CNT_BITS-1:0] LAST_FULL = CNT_BITS'(2*NUM_WRDS-1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_MUL   = 2'd1;
    localparam logic [1:0] ST_CARRY = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam logic [1:0] MODE_SQR = 2'd1;
    localparam logic [1:0] MODE_LOW = 2'd3;
`ifdef REDUN_MUL_ADD_TERM_EN
    localparam logic [1:0] MODE_MAC = 2'd2;
`endif

    logic [1:0]          state;
    logic [1:0]          ctl_q;
    logic [CNT_BITS-1:0] cnt;
    logic [WB-1:0]       a_q      [NUM_WRDS];
    logic [WB-1:0]       b_q      [NUM_WRDS];
    logic [ACC_BITS-1:0] acc      [2*NUM_WRDS];
    logic [ACC_BITS-1:0] acc_nxt  [2*NUM_WRDS];
    logic [WB-1:0]       res      [2*NUM_WRDS];
    logic [WB-1:0]       res_fin  [2*NUM_WRDS];
    logic [2*WB-1:0]     prod     [NUM_WRDS];
    logic [ACC_BITS-1:0] carry;
    logic [ACC_BITS-1:0] acc_sel;
    logic [ACC_BITS-1:0] sum;
    logic [WB-1:0]       a_sel;
    logic [WB-1:0]       word_val;
    logic [RES_BITS-1:0] dat_nxt;
    logic                low_mode;
    logic                last_carry;

`ifndef REDUN_MUL_ADD_TERM_EN
    logic unused_add_term;
    assign unused_add_term = ^i_add_term;
`endif

    assign o_rdy    = (state == ST_IDLE);
    assign low_mode = (ctl_q == MODE_LOW);

    // One row of partial products per MUL cycle: A[cnt] times every word of B.
    always_comb begin
        a_sel = '0;
        for (int i = 0; i < NUM_WRDS; i++) begin
            if (cnt == CNT_BITS'(i)) a_sel = a_q[i];
        end
        for (int j = 0; j < NUM_WRDS; j++) begin
            prod[j] = (2*WB)'(a_sel) * (2*WB)'(b_q[j]);
        end
        for (int k = 0; k < 2*NUM_WRDS; k++) acc_nxt[k] = acc[k];
        for (int i = 0; i < NUM_WRDS; i++) begin
            for (int j = 0; j < NUM_WRDS; j++) begin
                if (cnt == CNT_BITS'(i) && (!low_mode || (i + j) < NUM_WRDS))
                    acc_nxt[i+j] = acc_nxt[i+j] + ACC_BITS'(prod[j]);
            end
        end
    end

    // The top word of a full-width result keeps its redundant bit; low-half truncates.
    always_comb begin
        acc_sel = '0;
        for (int k = 0; k < 2*NUM_WRDS; k++) begin
            if (cnt == CNT_BITS'(k)) acc_sel = acc[k];
        end
        sum        = acc_sel + carry;
        last_carry = (cnt == (low_mode ? LAST_HALF : LAST_FULL));
        word_val   = (last_carry && !low_mode) ? sum[WB-1:0] : {1'b0, sum[WRD_BITS-1:0]};
        dat_nxt    = '0;
        for (int k = 0; k < 2*NUM_WRDS; k++) begin
            res_fin[k]            = (cnt == CNT_BITS'(k)) ? word_val : res[k];
            dat_nxt[k*WB +: WB]   = res_fin[k];
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= ST_IDLE;
            ctl_q <= '0;
            cnt   <= '0;
            carry <= '0;
            o_val <= 1'b0;
            o_ctl <= '0;
            o_dat <= '0;
            for (int i = 0; i < NUM_WRDS; i++) begin
                a_q[i] <= '0;
                b_q[i] <= '0;
            end
            for (int k = 0; k < 2*NUM_WRDS; k++) begin
                acc[k] <= '0;
                res[k] <= '0;
            end
        end else begin
            case (state)
                ST_IDLE: begin
                    if (i_val) begin
                        ctl_q <= i_ctl;
                        cnt   <= '0;
                        carry <= '0;
                        for (int i = 0; i < NUM_WRDS; i++) begin
                            a_q[i] <= i_dat_a[i*WB +: WB];
                            b_q[i] <= (i_ctl == MODE_SQR) ? i_dat_a[i*WB +: WB] : i_dat_b[i*WB +: WB];
                        end
                        for (int k = 0; k < 2*NUM_WRDS; k++) begin
                            acc[k] <= '0;
                            res[k] <= '0;
                        end
`ifdef REDUN_MUL_ADD_TERM_EN
                        if (i_ctl == MODE_MAC) begin
                            for (int i = 0; i < NUM_WRDS; i++)
                                acc[i] <= ACC_BITS'(i_add_term[i*WB +: WB]);
                        end
`endif
                        state <= ST_MUL;
                    end
                end
                ST_MUL: begin
                    for (int k = 0; k < 2*NUM_WRDS; k++) acc[k] <= acc_nxt[k];
                    if (cnt == LAST_HALF) begin
                        cnt   <= '0;
                        state <= ST_CARRY;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_CARRY: begin
                    carry <= sum >> WRD_BITS;
                    for (int k = 0; k < 2*NUM_WRDS; k++) res[k] <= res_fin[k];
                    if (last_carry) begin
                        o_dat <= dat_nxt;
                        o_ctl <= ctl_q;
                        o_val <= 1'b1;
                        state <= ST_DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    if (i_rdy) begin
                        o_val <= 1'b0;
                        state <= ST_IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_redun_mul_seq.sv
// Directed and randomised checks of redun_mul_seq (N=3, W=16) against a modulo reference.
`timescale 1ns/1ps
module tb_redun_mul_seq;

    localparam int N    = 3;
    localparam int W    = 16;
    localparam int WB   = W + 1;
    localparam int OPW  = N*WB;
    localparam int RESW = 2*N*WB;

    logic            i_clk = 1'b0;
    logic            i_rst;
    logic            i_val;
    logic            o_rdy;
    logic [1:0]      i_ctl;
    logic [OPW-1:0]  i_dat_a;
    logic [OPW-1:0]  i_dat_b;
    logic [OPW-1:0]  i_add_term;
    logic            o_val;
    logic            i_rdy;
    logic [1:0]      o_ctl;
    logic [RESW-1:0] o_dat;

    int errors = 0;
    int checks = 0;

    redun_mul_seq #(.NUM_WRDS(N), .WRD_BITS(W)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_val(i_val), .o_rdy(o_rdy),
        .i_ctl(i_ctl), .i_dat_a(i_dat_a), .i_dat_b(i_dat_b), .i_add_term(i_add_term),
        .o_val(o_val), .i_rdy(i_rdy), .o_ctl(o_ctl), .o_dat(o_dat)
    );

    always #5 i_clk = ~i_clk;

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [OPW-1:0] mk(input logic [WB-1:0] w0, input logic [WB-1:0] w1,
                                          input logic [WB-1:0] w2);
        return {w2, w1, w0};
    endfunction

    function automatic logic [OPW-1:0] rand_op();
        logic [OPW-1:0] v;
        for (int i = 0; i < N; i++) v[i*WB +: WB] = WB'($urandom_range(0, (1 << WB) - 1));
        return v;
    endfunction

    function automatic logic [127:0] op_value(input logic [OPW-1:0] v);
        logic [127:0] s = '0;
        for (int i = 0; i < N; i++) s = s + (128'(v[i*WB +: WB]) << (i*W));
        return s;
    endfunction

    function automatic logic [127:0] result_value(input logic [RESW-1:0] v);
        logic [127:0] s = '0;
        for (int i = 0; i < 2*N; i++) s = s + (128'(v[i*WB +: WB]) << (i*W));
        return s;
    endfunction

    // Reference: plain big-integer arithmetic reduced by the mode's modulus.
    function automatic logic [127:0] ref_model(input logic [1:0] ctl, input logic [OPW-1:0] a,
                                               input logic [OPW-1:0] b, input logic [OPW-1:0] c);
        logic [127:0] av, bv, p;
        av = op_value(a);
        bv = (ctl == 2'd1) ? av : op_value(b);
        p  = av * bv;
`ifdef REDUN_MUL_ADD_TERM_EN
        if (ctl == 2'd2) p = p + op_value(c);
`else
        if (ctl == 2'd2) p = p + 128'(c[0] & 1'b0);
`endif
        if (ctl == 2'd3) p = p & ((128'd1 << (N*W)) - 128'd1);
        else             p = p & ((128'd1 << (2*N*W + 1)) - 128'd1);
        return p;
    endfunction

    function automatic int exp_lat(input logic [1:0] ctl);
        return (ctl == 2'd3) ? 1 + 2*N : 1 + 3*N;
    endfunction

    task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [1:0] ctl, input logic [OPW-1:0] a,
                                 input logic [OPW-1:0] b, input logic [OPW-1:0] c);
        int guard = 0;
        while (o_rdy !== 1'b1 && guard < 100) begin
            tick();
            guard++;
        end
        checkOutput("accept_ready", 128'(o_rdy), 128'd1);
        i_ctl      = ctl;
        i_dat_a    = a;
        i_dat_b    = b;
        i_add_term = c;
        i_val      = 1'b1;
        tick();
        i_val      = 1'b0;
        i_ctl      = 2'($urandom);
        i_dat_a    = rand_op();
        i_dat_b    = rand_op();
        i_add_term = rand_op();
    endtask

    task automatic waitResult(input string tag, input logic [1:0] exp_ctl, input logic [127:0] exp_val,
                              input int lat, input int stall);
        int              edges = 0;
        logic [127:0]    hi = '0;
        logic [RESW-1:0] held_dat;
        logic [1:0]      held_ctl;
        logic            stable = 1'b1;
        logic            rdy_low = 1'b1;
        i_rdy = (stall == 0);
        while (o_val !== 1'b1 && edges < 40) begin
            tick();
            edges++;
        end
        checkOutput({tag, "_latency"}, 128'(edges + 1), 128'(lat));
        checkOutput({tag, "_value"}, result_value(o_dat), exp_val);
        checkOutput({tag, "_ctl"}, 128'(o_ctl), 128'(exp_ctl));
        for (int i = 0; i < 2*N - 1; i++) hi[i] = o_dat[i*WB + W];
        checkOutput({tag, "_normal_form"}, hi, 128'd0);
        if (stall > 0) begin
            held_dat = o_dat;
            held_ctl = o_ctl;
            repeat (stall) begin
                tick();
                if (o_val !== 1'b1 || o_dat !== held_dat || o_ctl !== held_ctl) stable = 1'b0;
                if (o_rdy !== 1'b0) rdy_low = 1'b0;
            end
            checkOutput({tag, "_hold_stable"}, 128'(stable), 128'd1);
            checkOutput({tag, "_hold_rdy_low"}, 128'(rdy_low), 128'd1);
            i_rdy = 1'b1;
        end
        tick();
        checkOutput({tag, "_released"}, 128'({o_val, o_rdy}), 128'b01);
    endtask

    logic [OPW-1:0] op_a, op_b, op_c;
    logic [1:0]     rnd_ctl;
    logic           seen_val;

    localparam logic [127:0] EXP_FULL = 128'h0000_FFFE_0003_0001_FFFD_0004_0004;
    localparam logic [127:0] EXP_LOW  = 128'h0000_0000_0000_0000_FFFD_0004_0004;

    initial begin
        i_rst = 1'b1; i_val = 1'b0; i_rdy = 1'b1; i_ctl = '0;
        i_dat_a = '0; i_dat_b = '0; i_add_term = '0;
        repeat (2) tick();
        checkOutput("reset_rdy", 128'(o_rdy), 128'd1);
        checkOutput("reset_val", 128'(o_val), 128'd0);
        checkOutput("reset_ctl", 128'(o_ctl), 128'd0);
        checkOutput("reset_dat", 128'(o_dat), 128'd0);
        i_rst = 1'b0;
        tick();

        op_a = mk(17'd2, 17'd1, 17'h0FFFF);
        $display("[TB] directed A*B");
        applyStimulus(2'd0, op_a, op_a, '0);
        waitResult("mul_ab", 2'd0, EXP_FULL, 10, 0);

        $display("[TB] directed A*A with garbage B");
        applyStimulus(2'd1, op_a, rand_op(), rand_op());
        waitResult("mul_sqr", 2'd1, EXP_FULL, 10, 0);

        $display("[TB] directed low-half");
        applyStimulus(2'd3, op_a, op_a, '0);
        waitResult("mul_low", 2'd3, EXP_LOW, 7, 0);

        $display("[TB] directed A*B+C");
        applyStimulus(2'd2, op_a, op_a, mk(17'd1, 17'd0, 17'd0));
`ifdef REDUN_MUL_ADD_TERM_EN
        waitResult("mul_mac", 2'd2, EXP_FULL + 128'd1, 10, 0);
`else
        waitResult("mul_mac", 2'd2, EXP_FULL, 10, 0);
`endif

        $display("[TB] backpressure then immediate accept");
        applyStimulus(2'd0, op_a, op_a, '0);
        waitResult("stall", 2'd0, EXP_FULL, 10, 5);
        op_b = mk(17'h1FFFF, 17'h1FFFF, 17'h1FFFF);
        applyStimulus(2'd1, op_b, '0, '0);
        waitResult("max_sqr", 2'd1, ref_model(2'd1, op_b, op_b, '0), 10, 0);

        $display("[TB] reset and valid in the same cycle");
        i_ctl = 2'd0; i_dat_a = op_a; i_dat_b = op_a;
        i_rst = 1'b1; i_val = 1'b1;
        tick();
        i_rst = 1'b0; i_val = 1'b0;
        checkOutput("rst_val_rdy", 128'(o_rdy), 128'd1);
        seen_val = 1'b0;
        repeat (14) begin
            tick();
            if (o_val !== 1'b0 || o_rdy !== 1'b1) seen_val = 1'b1;
        end
        checkOutput("rst_val_nothing_accepted", 128'(seen_val), 128'd0);

        $display("[TB] reset during carry pass");
        applyStimulus(2'd0, op_a, op_a, '0);
        repeat (5) tick();
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        checkOutput("rst_carry_outputs", 128'({o_rdy, o_val, o_ctl}), 128'b1000);
        checkOutput("rst_carry_dat", 128'(o_dat), 128'd0);
        seen_val = 1'b0;
        repeat (14) begin
            tick();
            if (o_val !== 1'b0) seen_val = 1'b1;
        end
        checkOutput("rst_carry_no_result", 128'(seen_val), 128'd0);

        $display("[TB] random transactions");
        for (int t = 0; t < 1000; t++) begin
            rnd_ctl = 2'($urandom_range(0, 3));
            op_a = rand_op();
            op_b = rand_op();
            op_c = rand_op();
            repeat ($urandom_range(0, 2)) tick();
            applyStimulus(rnd_ctl, op_a, op_b, op_c);
            waitResult("rnd", rnd_ctl, ref_model(rnd_ctl, op_a, op_b, op_c), exp_lat(rnd_ctl),
                       int'($urandom_range(0, 3)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/redun_mul_seq.md
# redun_mul_seq

Word-serial, handshaked multi-mode multiplier for redundant-form operands in the Montgomery datapath. It is the parametrised successor of the fully parallel multi-mode multiplier. One word of A is consumed per cycle into a 2N-word accumulator, followed by a serial carry-normalise pass. Modes are A*B, A*A, A*B+C and low-half A*B, selected per transaction. The block trades latency for a DSP count proportional to NUM_WRDS rather than NUM_WRDS², and sits where a reduced-area squaring/multiply unit is needed.

## Interface
- NUM_WRDS, 3, operand word count N (≥2)
- WRD_BITS, 16, radix bits W per word; operand words are W+1 bits (redundant)
- i_clk  in  1  clock
- i_rst  in  1  synchronous active-high reset
- i_val  in  1  input transaction valid
- o_rdy  out  1  block can accept input
- i_ctl  in  2  mode: 0 A*B, 1 A*A (i_dat_b ignored), 2 A*B+C, 3 low-half A*B
- i_dat_a  in  N×(W+1)  operand A, word i weight 2^(i·W)
- i_dat_b  in  N×(W+1)  operand B
- i_add_term  in  N×(W+1)  addend C (mode 2 only)
- o_val  out  1  result valid
- i_rdy  in  1  downstream accepts result
- o_ctl  out  2  mode of the transaction being presented
- o_dat  out  2N×(W+1)  normalised result

## Operation
- States: IDLE, MUL, CARRY, DONE.
- IDLE: o_rdy=1. Accept on i_val&o_rdy. Latch A, B (B:=A in mode 1), ctl. Clear accumulator; in mode 2, preload acc[i]=C[i] for i<N. Set wcnt=0. Go to MUL.
- MUL, N cycles: cycle wcnt does acc[wcnt+j] += A[wcnt]*B[j] for all j<N. In mode 3, only updates with wcnt+j<N occur. Go to CARRY after wcnt=N-1.
- Accumulator word width: 2(W+1)+clog2(N)+2 bits, so no overflow is possible.
- CARRY, K cycles: K=2N, or K=N in mode 3. Cycle k computes s=acc[k]+carry, out[k]=s[W-1:0], carry=s>>W.
  - Final word, non-low modes: out[2N-1]=s[W:0].
  - Final word, mode 3: out[N-1]=s[W-1:0]; words N..2N-1 are 0.
- DONE: o_val=1, with o_dat/o_ctl held stable until i_rdy. On o_val&i_rdy, go to IDLE.
- Result value: Σ o_dat[i]·2^(i·W).
  - Modes 0 and 1: (A·B) mod 2^(2NW+1).
  - Mode 2: (A·B+C) mod 2^(2NW+1).
  - Mode 3: (A·B) mod 2^(NW).
  - Words 0..2N-2 are always < 2^W.
- o_rdy=0 and i_val is ignored in MUL, CARRY and DONE. There is no overlap of transactions.

## Timing
- Accept at cycle T. o_val first high at cycle T+1+N+K: T+10 for N=3 in modes 0–2, T+7 in mode 3.
- o_rdy returns to 1 the cycle after the output handshake. Maximum throughput is one result per N+K+2 cycles.
- Reset values: o_rdy=1, o_val=0, o_ctl=0, o_dat=all 0, state IDLE, accumulator 0.
- Reset asserted in any state discards the transaction. On the following cycle all outputs are at reset values. No partial result is ever presented.
- i_rst and i_val in the same cycle: reset wins and nothing is accepted.
- Inputs are sampled only on the accept cycle. Later changes to inputs have no effect.
- o_dat, o_ctl and o_val are registered outputs.

## Configuration
- REDUN_MUL_ADD_TERM_EN defined: mode 2 behaves as above.
- Macro undefined:
  - The C preload logic and the i_add_term register are removed.
  - ctl=2 executes exactly as ctl=0 (o_ctl still reports 2).
  - i_add_term is unused.
- All other modes are unaffected either way.

## Test plan
- N=3, W=16. A=B={2,1,0xFFFF}, ctl=0, i_rdy=1. o_val exactly 10 cycles after accept, with o_dat = 0xFFFE_0003_0001_FFFD_0004_0004.
- Same A, ctl=1, B driven to random garbage. Identical result and latency.
- ctl=3, same operands. o_val at accept+7, o_dat = 0x0000_0000_0000_FFFD_0004_0004.
- ctl=2, C={1,0,0}, macro defined. Result 0xFFFE_0003_0001_FFFD_0004_0005. With the macro undefined, result …0004 and o_ctl=2.
- Backpressure: i_rdy low for 5 cycles after o_val rises. o_val, o_dat and o_ctl stay stable and o_rdy stays 0. Accept the next transaction the cycle after the i_rdy handshake.
- Random test: 1000 transactions over random modes, operand words up to 0x1FFFF, random i_val/i_rdy gaps. Compare every result against the modulo reference. Include one i_rst pulse during CARRY: expect no o_val for that transaction and o_rdy=1 on the next cycle.
